// File: rtl/muldiv_unit.sv
// muldiv_unit
// -----------
// Execute-stage multiply/divide unit that owns the architectural HI/LO
// registers. It handles mult, multu, div, divu, mthi and mtlo.
//
// The 64-bit result is computed combinationally when the operation is
// launched and is held in a pending register. `busy` then stays high for a
// fixed number of cycles, MULT_CYCLES or DIV_CYCLES. On the edge where busy
// falls, the pending result is committed to HI/LO. The hazard unit relies on
// `busy` to stall later md instructions and mfhi/mflo readers.
//
// Optional feature macro: MULDIV_CANCEL_EN
//   When defined, a `cancel` input is added. It aborts an in-flight
//   operation, suppresses a coincident start, and suppresses coincident
//   mthi/mtlo writes.
//
// Ports:
//   clk     in   1   system clock
//   reset   in   1   synchronous, active-high reset
//   start   in   1   one-cycle launch pulse for md_op
//   md_op   in   2   00 mult, 01 multu, 10 div, 11 divu
//   a       in  32   rs operand / mthi-mtlo write data
//   b       in  32   rt operand
//   wr_hi   in   1   mthi: HI <= a
//   wr_lo   in   1   mtlo: LO <= a
//   cancel  in   1   flush of owning instruction (MULDIV_CANCEL_EN only)
//   busy    out  1   operation in progress
//   hi      out 32   HI register
//   lo      out 32   LO register

module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
`ifdef MULDIV_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic cancel_i;
`ifdef MULDIV_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [63:0] pending_q, pending_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;

  // Arithmetic datapath.
  // Signed division is done on magnitudes so that it is well defined for
  // every operand, including INT_MIN / -1. The quotient is negated when the
  // operand signs differ. The remainder follows the sign of the dividend.
  logic        is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] a_ext, b_ext, prod, md_result;

  always_comb begin
    is_signed = ~md_op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    q_mag     = '0;
    r_mag     = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
    a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;
    md_result = md_op[1] ? {rem, quot} : prod;
  end

  // Next-state logic.
  // A divide by zero still runs its full busy sequence. Its pending result
  // is simply marked invalid, so HI/LO are left untouched at commit.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    busy_d          = busy_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel_i) begin
          pending_d       = md_result;
          pending_valid_d = !(md_op[1] && (b == 32'd0));
          count_d         = md_op[1] ? DIV_N : MULT_N;
          busy_d          = 1'b1;
          state_d         = RUN;
        end else if (!start && !cancel_i) begin
          if (wr_hi) hi_d = a;
          if (wr_lo) lo_d = a;
        end
      end
      RUN: begin
        if (cancel_i) begin
          pending_valid_d = 1'b0;
          count_d         = '0;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else if (count_q == 4'd1) begin
          if (pending_valid_q) begin
            hi_d = pending_q[63:32];
            lo_d = pending_q[31:0];
          end
          pending_valid_d = 1'b0;
          count_d         = '0;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  // Reset has the highest priority and discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      hi_q            <= '0;
      lo_q            <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      hi_q            <= hi_d;
      lo_q            <= lo_d;
      busy_q          <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit.
// Expected HI/LO values come from a behavioural model and are queued when an
// operation is launched. They are popped and compared on the cycle busy falls.
// Stimulus is driven on the falling edge, and outputs are sampled there too.

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, wr_hi, wr_lo;
  logic [1:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
`ifdef MULDIV_CANCEL_EN
  logic        cancel;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi, model_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
`ifdef MULDIV_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference model: returns {hi, lo} after the operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] oh,
                                        input logic [31:0] ol);
    longint sx, sy, sp;
    int     ix, iy, iq, ir;
    logic [63:0] up;
    model = {oh, ol};
    case (op)
      2'b00: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sp = sx * sy;
        model = sp;
      end
      2'b01: begin
        up = {32'd0, x} * {32'd0, y};
        model = up;
      end
      2'b10: if (y != 32'd0) begin
        ix = $signed(x);
        iy = $signed(y);
        iq = ix / iy;
        ir = ix % iy;
        model = {ir, iq};
      end
      default: if (y != 32'd0) model = {x % y, x / y};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches one operation and pushes its expected result to the scoreboard.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] r;
    r = model(op, x, y, model_hi, model_lo);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.cycles = op[1] ? 10 : 5;
    model_hi = e.hi;
    model_lo = e.lo;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Counts busy cycles and can inject an ignored start or mtlo mid-run.
  // When busy falls, the scoreboard entry is popped and compared.
  task automatic waitAndCheck(input string tag, input int start_at, input int wrlo_at);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      start = (cnt == start_at);
      md_op = 2'b00;
      wr_lo = (cnt == wrlo_at);
      if (cnt == wrlo_at) a = 32'hDEADBEEF;
      @(negedge clk);
    end
    start = 1'b0;
    wr_lo = 1'b0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_busy_cycles"}, 64'(cnt), 64'(e.cycles));
      checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
      checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    md_op = 2'b00; a = '0; b = '0;
`ifdef MULDIV_CANCEL_EN
    cancel = 1'b0;
`endif
    model_hi = '0; model_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);

    applyStimulus(2'b00, 32'hFFFFFFFF, 32'h00000002);
    waitAndCheck("mult", 0, 0);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'h00000002);
    waitAndCheck("multu", 0, 0);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'h00000002);
    waitAndCheck("div", 0, 0);
    applyStimulus(2'b11, 32'h00000007, 32'h00000002);
    waitAndCheck("divu", 0, 0);
    applyStimulus(2'b00, 32'h80000000, 32'h80000000);
    waitAndCheck("mult_minmin", 0, 0);
    applyStimulus(2'b10, 32'h00000007, 32'hFFFFFFFE);
    waitAndCheck("div_negdivisor", 0, 0);

    // mthi in idle
    @(negedge clk);
    wr_hi = 1'b1; a = 32'h12345678;
    @(negedge clk);
    wr_hi = 1'b0;
    model_hi = 32'h12345678;
    checkOutput("mthi", {32'd0, hi}, 64'h12345678);

    // divide by zero, with an ignored restart and an ignored mtlo mid-run
    applyStimulus(2'b10, 32'h00000055, 32'h00000000);
    waitAndCheck("divzero", 4, 6);

    // reset mid-operation aborts and clears
    applyStimulus(2'b01, 32'h00001000, 32'h00001000);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, lo}, 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("abort_late_busy", 64'(busy), 64'd0);
    checkOutput("abort_late_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_late_lo", {32'd0, lo}, 64'd0);

`ifdef MULDIV_CANCEL_EN
    // cancel mid-run leaves pre-start HI/LO in place
    @(negedge clk);
    wr_hi = 1'b1; a = 32'h0000000A;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; a = 32'h0000000B;
    @(negedge clk);
    wr_lo = 1'b0;
    @(negedge clk);
    start = 1'b1; md_op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("cancel_hi", {32'd0, hi}, 64'h0000000A);
    checkOutput("cancel_lo", {32'd0, lo}, 64'h0000000B);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
